// File: rtl/kyber_pkg.sv
// Shared constants for the coefficient compress/decompress blocks:
// the modulus, its rounding half, and the reciprocal used for the
// divide-by-Q.
package kyber_pkg;

  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned HALF_Q      = (KYBER_Q - 32'd1) / 32'd2;

  // Widest numerator is 4095 * 2^11 + 2047 = 2^23 - 1, so 24 bits leaves
  // headroom for every legal D.
  localparam int unsigned NUM_W       = 24;

  // The reciprocal is scaled by 2^RECIP_SHIFT. Because every numerator is
  // below 2^RECIP_SHIFT, the estimate is never more than one below the
  // true quotient, so a single correction step is enough.
  localparam int unsigned RECIP_SHIFT = 24;
  localparam int unsigned RECIP_W     = 25;

  // floor(2^RECIP_SHIFT / q), evaluated at elaboration time only
  function automatic logic [RECIP_W-1:0] recip_of(input int unsigned q);
    logic [63:0] one_s;
    one_s = 64'd1 << RECIP_SHIFT;
    return RECIP_W'(one_s / 64'(q));
  endfunction

  // (q - 1) / 2, the rounding offset for an odd modulus
  function automatic int unsigned half_of(input int unsigned q);
    return (q - 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/div_by_q.sv
// Exact combinational floor(num / Q) for any num below 2^NUM_W.
// A multiply by the scaled reciprocal gives an estimate that is either
// exact or one too small; one remainder check fixes the latter case.
module div_by_q
  import kyber_pkg::*;
#(
  parameter int unsigned Q = KYBER_Q
) (
  input  logic [NUM_W-1:0] num,
  output logic [NUM_W-1:0] quot
);

  localparam logic [RECIP_W-1:0] RECIP = recip_of(Q);
  localparam logic [11:0]        Q_W   = 12'(Q);

  logic [NUM_W+RECIP_W-1:0] prod_s;
  logic [NUM_W-1:0]         est_s;
  logic [NUM_W+11:0]        back_s;
  logic [NUM_W+11:0]        rem_s;

  // Reciprocal estimate followed by a one-step remainder correction
  always_comb begin
    prod_s = {{RECIP_W{1'b0}}, num} * {{NUM_W{1'b0}}, RECIP};
    est_s  = NUM_W'(prod_s >> RECIP_SHIFT);
    back_s = {12'd0, est_s} * {{NUM_W{1'b0}}, Q_W};
    rem_s  = {12'd0, num} - back_s;
    if (rem_s >= {{NUM_W{1'b0}}, Q_W}) begin
      quot = est_s + {{(NUM_W-1){1'b0}}, 1'b1};
    end else begin
      quot = est_s;
    end
  end

endmodule

// File: rtl/compress.sv
// Compress_D: out_val = round(in_val * 2^D / Q) mod 2^D, registered,
// one result per clock with a single cycle of latency. Inputs at or
// above Q are used as-is; the quotient is simply truncated to D bits,
// which also folds a quotient of exactly 2^D back to 0.
module compress
  import kyber_pkg::*;
#(
  parameter int unsigned D = 10,
  parameter int unsigned Q = KYBER_Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  in_val,
  output logic [D-1:0] out_val
);

  localparam logic [NUM_W-1:0] HALF_W = NUM_W'(half_of(Q));

  logic [NUM_W-1:0] num_s;
  logic [NUM_W-1:0] quot_s;

  // Scale by 2^D and add the rounding offset before the floor division
  always_comb begin
    num_s = ({12'd0, in_val} << D) + HALF_W;
  end

  div_by_q #(
    .Q (Q)
  ) u_div_by_q (
    .num  (num_s),
    .quot (quot_s)
  );

  // Output register; keeping the low D bits implements the mod 2^D wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val <= {D{1'b0}};
    end else begin
      out_val <= D'(quot_s);
    end
  end

endmodule

// File: tb/tb_compress.sv
// Directed bench for compress: three instances (D = 1, 4, 10) share one
// input. Hand-computed vectors, a full 0..4095 sweep against an integer
// reference, and asynchronous reset in the middle of the sweep.
module tb_compress;

  logic        clk;
  logic        rst;
  logic [11:0] in_val;
  logic [0:0]  out_d1;
  logic [3:0]  out_d4;
  logic [9:0]  out_d10;

  int errors;
  int checks;

  compress #(.D(1))  u_d1  (.clk(clk), .rst(rst), .in_val(in_val), .out_val(out_d1));
  compress #(.D(4))  u_d4  (.clk(clk), .rst(rst), .in_val(in_val), .out_val(out_d4));
  compress #(.D(10)) u_d10 (.clk(clk), .rst(rst), .in_val(in_val), .out_val(out_d10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor((x*2^d + 1664) / 3329) mod 2^d using plain integer division
  function automatic logic [31:0] model(input int x, input int d);
    longint n;
    longint q;
    n = (longint'(x) << d) + 64'd1664;
    q = n / 64'd3329;
    return 32'(q % (64'd1 << d));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e4,
                         input logic [31:0] e10);
    chk({tag, "_d1"},  {31'd0, out_d1},  e1);
    chk({tag, "_d4"},  {28'd0, out_d4},  e4);
    chk({tag, "_d10"}, {22'd0, out_d10}, e10);
  endtask

  // Apply x away from the active edge, then sample just after the next edge
  task automatic apply(input logic [11:0] x);
    @(negedge clk);
    in_val = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    in_val = 12'd1664;

    // Reset state with a non-zero input present
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'd0, 32'd0, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    // Hand-computed vectors
    apply(12'd0);    chk("v0_d10",    {22'd0, out_d10}, 32'd0);
    apply(12'd1);    chk("v1_d10",    {22'd0, out_d10}, 32'd0);
    apply(12'd2);    chk("v2_d10",    {22'd0, out_d10}, 32'd1);
    apply(12'd1664); chk("v1664_d10", {22'd0, out_d10}, 32'd512);
                     chk("v1664_d4",  {28'd0, out_d4},  32'd8);
                     chk("v1664_d1",  {31'd0, out_d1},  32'd1);
    apply(12'd3328); chk("wrap3328_d10", {22'd0, out_d10}, 32'd0);
    apply(12'd4095); chk("v4095_d10", {22'd0, out_d10}, 32'd236);
                     chk("v4095_d4",  {28'd0, out_d4},  32'd4);
                     chk("v4095_d1",  {31'd0, out_d1},  32'd0);
    apply(12'd1000); chk("v1000_d4",  {28'd0, out_d4},  32'd5);
    apply(12'd832);  chk("v832_d1",   {31'd0, out_d1},  32'd0);
    apply(12'd833);  chk("v833_d1",   {31'd0, out_d1},  32'd1);
    apply(12'd2496); chk("v2496_d1",  {31'd0, out_d1},  32'd1);
    apply(12'd2497); chk("v2497_d1",  {31'd0, out_d1},  32'd0);

    // Back-to-back sweep, one value per cycle, with a reset pulse in the middle
    for (int x = 0; x < 4096; x++) begin
      apply(12'(x));
      chk_all("sweep", model(x, 1), model(x, 4), model(x, 10));
      if (x == 1664) begin
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        in_val = 12'd777;
        @(posedge clk);
        #1;
        chk_all("rst_held", 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        in_val = 12'd1234;
        @(posedge clk);
        #1;
        chk_all("first_after_rst", model(1234, 1), model(1234, 4), model(1234, 10));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compress.md
COMPRESS -- requirements
Module: compress

Interface
REQ-001 The block SHALL have parameter D, default 10, giving the compressed output width in bits; legal values are 1..11, and 1, 4, 10 and 11 SHALL be supported.
REQ-002 The block SHALL have parameter Q, default 3329, giving the modulus; Q SHALL be odd and less than 4096.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_val, input, width 12: the coefficient to compress, unsigned.
REQ-006 The block SHALL have port out_val, output, width D: the compressed coefficient, driven directly from a register.

Function
REQ-007 out_val SHALL equal Compress_D(x) = round(x * 2^D / Q) mod 2^D, where x is in_val as an unsigned integer.
REQ-008 Rounding SHALL be computed exactly as floor((x * 2^D + (Q-1)/2) / Q); because Q is odd, no exact-half ties exist.
REQ-009 The division SHALL be exact for every 12-bit x; floating point or approximate reciprocals that err for any x in 0..4095 are not allowed.
REQ-010 Inputs x >= Q (Q..4095) SHALL NOT be reduced mod Q first; the same formula SHALL apply, and the quotient SHALL be truncated to its D LSBs.
REQ-011 Wrap-around: a quotient equal to 2^D (e.g. x near Q) SHALL yield 0.
REQ-012 Latency SHALL be exactly 1 clock: in_val sampled at rising edge n appears on out_val after edge n.
REQ-013 The block SHALL accept a new input every cycle (throughput 1 per clock), with no handshake and no stall.
REQ-014 Internal arithmetic SHALL be sized to hold 4095*2^D + (Q-1)/2 without overflow (at least 12+D+1 bits).

Reset
REQ-015 While rst=1, out_val SHALL be 0, with asynchronous assertion.
REQ-016 When rst is deasserted, the first valid out_val SHALL appear after the first rising edge with rst=0, and SHALL reflect in_val at that edge.
REQ-017 If rst asserts mid-stream, the pending result SHALL be discarded and out_val SHALL be forced to 0 immediately.

Structure
REQ-018 The constants Q and HALF_Q = (Q-1)/2, and any reciprocal/shift constants derived from them, SHALL reside in a shared package (kyber_pkg) reused by decompress.
REQ-019 The exact divide-by-Q SHALL be implemented in one combinational sub-module, div_by_q, using multiply-by-reciprocal plus a single correction step, so that it needs no divider operator.
REQ-020 compress SHALL instantiate div_by_q once, followed by the output register.
REQ-021 Multiple instances with different D SHALL coexist in one design driven from the same in_val.

Verification
REQ-022 Scenario: with D=10, in_val 0, 1, 2, 1664, 3328 SHALL give out_val 0, 0, 1, 512 and 0 (wrap) respectively, one cycle later.
REQ-023 Scenario: with D=10, in_val 4095 SHALL give 236; with D=4, in_val 1000 SHALL give 5 and in_val 4095 SHALL give 4.
REQ-024 Scenario: with D=1, in_val 832, 833, 2496, 2497 and 4095 SHALL give 0, 1, 1, 0 and 0 respectively.
REQ-025 Scenario: an exhaustive sweep of in_val 0..4095, one value per cycle for D=1, 4 and 10 in parallel, SHALL match a software model of REQ-008/REQ-010 with 1-cycle latency and zero mismatches.
REQ-026 Scenario: asserting rst mid-sweep SHALL force out_val to 0 asynchronously (before the next edge), and the first output after release SHALL match the input at the first edge with rst=0.
